// File: rtl/not_32_unit.sv
// 32-bit bitwise inverter: combinational ~A for the single-cycle ALU path, plus an
// independent one-entry valid/ready register stage carrying ~A to pipelined consumers.
module not_32_unit (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] A,
    output logic [31:0] Out,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] Out_q,
    output logic        out_valid,
    input  logic        out_ready
);

    logic        accept;
    logic        drain;
    logic [31:0] out_d;
    logic        valid_d;

    // One inverter per bit; no shared logic between bit lanes.
    for (genvar i = 0; i < 32; i++) begin : g_inv
        assign Out[i] = ~A[i];
    end

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    always_comb begin
        out_d   = Out_q;
        valid_d = out_valid;
        if (accept) begin
            out_d   = ~A;
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            Out_q     <= 32'h0000_0000;
            out_valid <= 1'b0;
        end else begin
            Out_q     <= out_d;
            out_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_not_32_unit.sv
// Self-checking bench for not_32_unit: vector table for the combinational path and
// hand-written handshake sequences, with a scoreboard queue for streaming.
module tb_not_32_unit;

    logic        clock;
    logic        resetn;
    logic [31:0] A;
    logic [31:0] Out;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Out_q;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] sb_q[$];
    logic [31:0] exp_w;
    logic [31:0] rnd;

    not_32_unit dut (
        .clock    (clock),
        .resetn   (resetn),
        .A        (A),
        .Out      (Out),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Out_q    (Out_q),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] req);
        checks++;
        if (actual !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, req);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        resetn    = 1'b0;
        A         = 32'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{a: 32'h0000_0000, exp: 32'hFFFF_FFFF};
        vecs[1] = '{a: 32'hFFFF_FFFF, exp: 32'h0000_0000};
        vecs[2] = '{a: 32'h1234_5678, exp: 32'hEDCB_A987};
        vecs[3] = '{a: 32'hAAAA_AAAA, exp: 32'h5555_5555};

        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_q", Out_q, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Combinational path works while reset is still asserted.
        for (int i = 0; i < 4; i++) begin
            A = vecs[i].a;
            #20;
            check($sformatf("vec%0d", i), Out, vecs[i].exp);
        end

        for (int i = 0; i < 10; i++) begin
            rnd   = $random;
            A     = rnd;
            exp_w = ~rnd;
            #20;
            $display("rand %0d: A=%h Out=%h exp=%h equal=%0d", i, A, Out, exp_w, Out === exp_w);
            check("rand_out", Out, exp_w);
        end

        @(negedge clock);
        resetn = 1'b1;

        // Fill the stage, then reset mid-cycle.
        @(negedge clock);
        A         = 32'hFFFF_0000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        check("pre_rst_out_q", Out_q, 32'h0000_FFFF);
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_q", Out_q, 32'h0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        A = 32'h1357_2468;
        #1;
        check("rst_comb", Out, 32'hECA8_DB97);
        in_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;

        // Single transfer into a stalled consumer.
        @(negedge clock);
        A        = 32'h0F0F_0F0F;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        check("single_out_q", Out_q, 32'hF0F0_F0F0);
        check("single_valid", {31'b0, out_valid}, 32'd1);
        check("single_in_ready", {31'b0, in_ready}, 32'd0);
        A = 32'h1234_5678;
        @(posedge clock);
        #1;
        check("full_hold_out_q", Out_q, 32'hF0F0_F0F0);
        check("full_hold_valid", {31'b0, out_valid}, 32'd1);

        // Drain with simultaneous accept, then drain only.
        @(negedge clock);
        out_ready = 1'b1;
        A         = 32'h0000_0001;
        #1;
        check("drain_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        check("b2b_out_q", Out_q, 32'hFFFF_FFFE);
        check("b2b_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("drained_valid", {31'b0, out_valid}, 32'd0);
        check("drained_out_q", Out_q, 32'hFFFF_FFFE);

        // Streaming: one accept per cycle, scoreboard checks order and data.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            rnd      = $urandom;
            A        = rnd;
            in_valid = 1'b1;
            #1;
            check("stream_in_ready", {31'b0, in_ready}, 32'd1);
            sb_q.push_back(~rnd);
            @(posedge clock);
            #1;
            check("stream_valid", {31'b0, out_valid}, 32'd1);
            if (sb_q.size() > 0) begin
                exp_w = sb_q.pop_front();
                check("stream_out_q", Out_q, exp_w);
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("stream_end_valid", {31'b0, out_valid}, 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/not_32_unit.md
# not_32_unit

32-bit bitwise inverter for the processor ALU datapath. Provides a purely combinational result (`Out = ~A`) for the ALU's single-cycle NOT path. Also provides a one-deep registered copy of the result with a valid/ready handshake, for use by pipelined consumers. The combinational path is built structurally from 32 single-bit inverters; the registered path is an independent pipeline stage fed by the same input.

## Interface
Parameters:
- None; width is fixed at 32 bits.

Ports:
- clock  input  1  rising-edge clock; one clock domain for the block.
- resetn  input  1  reset, asynchronous and active-low.
  - Asserting it (0) immediately clears all registered state.
  - Deassertion is expected to be synchronous to `clock`.
- A  input  32  operand.
- Out  output  32  combinational result, `~A`.
- in_valid  input  1  `A` carries an operand to be captured by the registered stage.
- in_ready  output  1  the registered stage can accept an operand this cycle.
- Out_q  output  32  registered result.
- out_valid  output  1  `Out_q` holds an undelivered result.
- out_ready  input  1  the downstream consumer takes `Out_q` this cycle.

## Operation
- Combinational path:
  - `Out[i] = ~A[i]` for every i in 0..31; no arithmetic and no carries.
  - Independent of `clock`, `resetn` and all handshake signals.
  - Valid even while reset is asserted.
- Registered stage, one entry:
  - `in_ready = ~out_valid | out_ready` (combinational pass-through of downstream ready).
  - accept = `in_valid & in_ready`.
  - drain = `out_valid & out_ready`.
- On a rising clock edge with `resetn` high:
  - accept: `Out_q <= ~A`; `out_valid <= 1`.
  - drain without accept: `out_valid <= 0`; `Out_q` holds its last value.
  - neither: all registered state holds.
- Simultaneous accept and drain:
  - the new result replaces the delivered one;
  - `out_valid` stays 1;
  - full throughput of one result per cycle.
- Full stage (`out_valid=1`, `out_ready=0`):
  - `in_ready=0`;
  - `in_valid` is ignored;
  - `Out_q` is stable until drained.
- `Out_q` is defined for every cycle but is meaningful only while `out_valid=1`.
- No X-propagation special-casing: an X on input bit i gives X on output bit i only.

## Timing
- `Out`: zero-cycle latency, combinational from `A`.
  - The bench settles 20 ns after changing `A` before comparing.
  - The path must meet that comfortably.
- `Out_q` / `out_valid`: one-cycle latency. Accept at edge N makes the data visible after edge N.
- Reset values, asynchronous on `resetn` falling:
  - `out_valid=0`;
  - `Out_q=32'h00000000`;
  - therefore `in_ready=1`.
- Reset mid-operation: any held, undelivered result is discarded. No partial state survives.
- First edge after `resetn` rises behaves as a normal edge; no dead cycle is required.
- `in_ready` and `Out` have no registered delay. Both follow their inputs within the same cycle.

## Test plan
- Combinational vectors:
  - A=32'h00000000 -> Out=32'hFFFFFFFF;
  - A=32'hFFFFFFFF -> Out=32'h00000000;
  - A=32'h12345678 -> Out=32'hEDCBA987;
  - A=32'hAAAAAAAA -> Out=32'h55555555.
- Random: 10 iterations of A=$random.
  - Wait 20 ns, compare `Out` against `~A`; must be equal every time.
  - Print A, Out, expected and equality.
- Reset: drive `resetn=0` mid-cycle with `out_valid=1`, `Out_q=32'h0000FFFF`.
  - Immediately `out_valid=0`, `Out_q=0`, `in_ready=1`.
  - `Out` keeps tracking `~A` during reset.
- Single transfer: `in_valid=1`, A=32'h0F0F0F0F, `out_ready=0` at edge 1.
  - After edge 1: `Out_q=32'hF0F0F0F0`, `out_valid=1`, `in_ready=0`.
  - A second operand offered at edge 2 is not captured.
- Drain and back-to-back:
  - With the stage full, set `out_ready=1` and present A=32'h00000001 with `in_valid=1`.
  - After the edge: `Out_q=32'hFFFFFFFE`, `out_valid=1`.
  - Then drop `in_valid`; after the next edge `out_valid=0`.
- Streaming: `out_ready=1`, `in_valid=1`, new A every cycle for 8 cycles.
  - Every cycle accepts.
  - `Out_q` equals `~A` of the previous cycle.
  - No bubbles.
